// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 8;
  localparam int unsigned NUM_STG  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Stage boundary indices into the stage control vector
  localparam logic [1:0] STG_IFID  = 2'd0;
  localparam logic [1:0] STG_IDEX  = 2'd1;
  localparam logic [1:0] STG_EXMEM = 2'd2;
  localparam logic [1:0] STG_MEMWB = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } ctrl_state_e;

  // Enable / synchronous clear pair for one pipeline register boundary
  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctl_t;

  localparam stage_ctl_t STG_FLOW   = '{en: 1'b1, clr: 1'b0};
  localparam stage_ctl_t STG_FREEZE = '{en: 1'b0, clr: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wbreg,
  output logic             load_use_c
);

  // Register zero is never a real dependency
  always_comb begin
    load_use_c = ex_memread && (ex_wbreg != REG_ZERO) &&
                 ((id_use_rs && (id_rs == ex_wbreg)) ||
                  (id_use_rt && (id_rt == ex_wbreg)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: EN/CLR for every stage boundary plus PC enable.
// Handles load-use stalls, taken-branch flushes, MUL/DIV stalls and SYSCALL halt/resume.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush/halt counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wbreg,
  input  logic             ex_branch_tkn,
  input  logic             ex_muldiv,
  input  logic             wb_halt,
  input  logic             go,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             clr_ifid,
  output logic             en_idex,
  output logic             clr_idex,
  output logic             en_exmem,
  output logic             clr_exmem,
  output logic             en_memwb,
  output logic             clr_memwb,
  output logic             halted,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] halt_cnt,
`endif
  output logic             md_busy
);

  ctrl_state_e                 state_q, state_d;
  logic [MD_CNT_W-1:0]         md_cnt_q, md_cnt_d;
  logic                        svc_q, svc_d;
  stage_ctl_t [NUM_STG-1:0]    stg;
  logic                        pc_en_c, halted_c, md_busy_c;
  logic                        load_use_c;

  load_use_detect u_lu (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_wbreg   (ex_wbreg),
    .load_use_c (load_use_c)
  );

  // State, MUL/DIV countdown and serviced flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
      svc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      svc_q    <= svc_d;
    end
  end

  // Next state and per-stage control; wb_halt outranks every other transition
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    svc_d     = svc_q;
    stg       = {NUM_STG{STG_FLOW}};
    pc_en_c   = 1'b1;
    halted_c  = 1'b0;
    md_busy_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // EX advances on every RUN cycle, so the op that was just serviced leaves
        svc_d = 1'b0;
        if (ex_branch_tkn) begin
          stg[STG_IFID].clr = 1'b1;
          stg[STG_IDEX].clr = 1'b1;
        end else if (load_use_c) begin
          pc_en_c           = 1'b0;
          stg[STG_IFID].en  = 1'b0;
          stg[STG_IDEX].clr = 1'b1;
        end
        if (wb_halt) begin
          state_d = ST_HALT;
        end else if (ex_muldiv && !svc_q) begin
          state_d  = ST_MULDIV;
          md_cnt_d = MD_CNT_W'(MD_LAT - 1);
        end
      end
      ST_MULDIV: begin
        pc_en_c            = 1'b0;
        stg[STG_IFID].en   = 1'b0;
        stg[STG_IDEX].en   = 1'b0;
        stg[STG_EXMEM].clr = 1'b1;
        md_busy_c          = 1'b1;
        if (wb_halt) begin
          state_d  = ST_HALT;
          md_cnt_d = '0;
        end else if (md_cnt_q == '0) begin
          state_d = ST_RUN;
          svc_d   = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
      ST_HALT: begin
        stg      = {NUM_STG{STG_FREEZE}};
        pc_en_c  = 1'b0;
        halted_c = 1'b1;
        // Clearing MEM/WB on resume drops the SYSCALL so it cannot re-halt
        if (go) begin
          state_d            = ST_RUN;
          stg[STG_MEMWB].clr = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Port drive; reset forces every boundary into clear
  always_comb begin
    if (!rst_n) begin
      pc_en     = 1'b0;
      en_ifid   = 1'b0;
      clr_ifid  = 1'b1;
      en_idex   = 1'b0;
      clr_idex  = 1'b1;
      en_exmem  = 1'b0;
      clr_exmem = 1'b1;
      en_memwb  = 1'b0;
      clr_memwb = 1'b1;
      halted    = 1'b0;
      md_busy   = 1'b0;
    end else begin
      pc_en     = pc_en_c;
      en_ifid   = stg[STG_IFID].en;
      clr_ifid  = stg[STG_IFID].clr;
      en_idex   = stg[STG_IDEX].en;
      clr_idex  = stg[STG_IDEX].clr;
      en_exmem  = stg[STG_EXMEM].en;
      clr_exmem = stg[STG_EXMEM].clr;
      en_memwb  = stg[STG_MEMWB].en;
      clr_memwb = stg[STG_MEMWB].clr;
      halted    = halted_c;
      md_busy   = md_busy_c;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_evt_c, flush_evt_c, halt_evt_c;

  // Counted events: stall cycles actually applied, flushes, entries into HALT
  always_comb begin
    stall_evt_c = (state_q == ST_MULDIV) ||
                  ((state_q == ST_RUN) && !ex_branch_tkn && load_use_c);
    flush_evt_c = (state_q == ST_RUN) && ex_branch_tkn;
    halt_evt_c  = (state_q != ST_HALT) && (state_d == ST_HALT);
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      halt_cnt  <= '0;
    end else begin
      if (stall_evt_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (halt_evt_c  && (halt_cnt  != '1)) halt_cnt  <= halt_cnt  + CNT_W'(1);
    end
  end
`endif

endmodule
